// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - one-at-a-time load/store front end for the CBG single-port word RAM (optional macro: RAM_ACC_BYTE_WE_EN)
`ifndef A_W
`define A_W 9
`endif
`ifndef RAM_DEEP
`define RAM_DEEP 256
`endif

module ram_access_ctrl #(
  parameter int ADDR_W  = `A_W-1,
  parameter int DEPTH   = `RAM_DEEP,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic              ram_read_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable and nothing is out of range.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
`ifdef RAM_ACC_BYTE_WE_EN
    RMW_WR,
`endif
    RSP
  } state_t;

  state_t            state, state_d;
  logic              hold_we, hold_we_d;
  logic [ADDR_W-1:0] hold_addr, hold_addr_d;
  logic [31:0]       hold_wdata, hold_wdata_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [31:0]       rdata_d;
  logic              err_d;
  logic              addr_oor;
  logic              full_word;

  assign addr_oor = ({1'b0, req_addr} >= DEPTH_W);
  assign ram_addr = hold_addr;

`ifdef RAM_ACC_BYTE_WE_EN
  logic [3:0]  hold_wstrb, hold_wstrb_d;
  logic [31:0] rd_word, rd_word_d;
  logic [31:0] merged;

  assign full_word = (hold_wstrb == 4'hF);

  // Strobed bytes come from the store data, the rest from the word just read.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (hold_wstrb[i]) merged[8*i +: 8] = hold_wdata[8*i +: 8];
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
  assign full_word    = 1'b1;
`endif

  // State and holding registers; everything clears asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      cnt        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef RAM_ACC_BYTE_WE_EN
      hold_wstrb <= '0;
      rd_word    <= '0;
`endif
    end else begin
      state      <= state_d;
      hold_we    <= hold_we_d;
      hold_addr  <= hold_addr_d;
      hold_wdata <= hold_wdata_d;
      cnt        <= cnt_d;
      rsp_rdata  <= rdata_d;
      rsp_err    <= err_d;
`ifdef RAM_ACC_BYTE_WE_EN
      hold_wstrb <= hold_wstrb_d;
      rd_word    <= rd_word_d;
`endif
    end
  end

  // Next-state, register updates and state-decoded outputs.
  always_comb begin
    state_d      = state;
    hold_we_d    = hold_we;
    hold_addr_d  = hold_addr;
    hold_wdata_d = hold_wdata;
    cnt_d        = cnt;
    rdata_d      = rsp_rdata;
    err_d        = rsp_err;
`ifdef RAM_ACC_BYTE_WE_EN
    hold_wstrb_d = hold_wstrb;
    rd_word_d    = rd_word;
`endif
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    ram_ena      = 1'b0;
    ram_wea      = 1'b0;
    ram_din      = '0;
    case (state)
      IDLE: begin
        // Gated by rst so ready stays low while reset is held.
        req_ready = rst;
        if (req_valid && rst) begin
          hold_we_d    = req_we;
          hold_addr_d  = req_addr;
          hold_wdata_d = req_wdata;
`ifdef RAM_ACC_BYTE_WE_EN
          hold_wstrb_d = req_wstrb;
`endif
          if (addr_oor) begin
            rdata_d = 32'hFFFF_FFFF;
            err_d   = 1'b1;
            state_d = RSP;
`ifdef RAM_ACC_BYTE_WE_EN
          end else if (req_we && (req_wstrb == 4'h0)) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = RSP;
`endif
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        ram_ena = 1'b1;
        ram_din = hold_wdata;
        cnt_d   = '0;
        if (hold_we && full_word) begin
          ram_wea = 1'b1;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RSP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt + 1'b1;
        if (ram_read_valid) begin
`ifdef RAM_ACC_BYTE_WE_EN
          if (hold_we) begin
            rd_word_d = ram_dout;
            state_d   = RMW_WR;
          end else begin
            rdata_d = ram_dout;
            err_d   = 1'b0;
            state_d = RSP;
          end
`else
          rdata_d = ram_dout;
          err_d   = 1'b0;
          state_d = RSP;
`endif
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
`ifdef RAM_ACC_BYTE_WE_EN
      RMW_WR: begin
        ram_ena = 1'b1;
        ram_wea = 1'b1;
        ram_din = merged;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RSP;
      end
`endif
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;

  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 200;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_wstrb = 4'hF;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;
  logic              ram_read_valid;

  int checks = 0;
  int errors = 0;
  int ena_cnt = 0;
  logic suppress_rv = 1'b0;
  logic [31:0] mem [0:255];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  ram_access_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_read_valid(ram_read_valid)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency with a read_valid pulse, optionally suppressed.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_read_valid <= 1'b0;
    end else begin
      ram_read_valid <= ram_ena && !ram_wea && !suppress_rv;
      if (ram_ena && !ram_wea) ram_dout <= mem[ram_addr];
      if (ram_ena && ram_wea) mem[ram_addr] <= ram_din;
    end
  end

  always @(posedge clk) if (ram_ena) ena_cnt <= ena_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] er, input logic ee,
                              input int el);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  // Drive one request, push its expectation, then pop and compare when the response shows up.
  task automatic do_req(input vec_t v, input bit wait_first);
    int lat;
    int ena_before;
    vec_t e;
    if (wait_first) @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb; rsp_ready = 1'b1;
    exp_q.push_back(v);
    ena_before = ena_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check("rsp_latency", 32'(lat), 32'(e.exp_lat));
    check("rsp_rdata", rsp_rdata, e.exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(e.exp_err));
    if (e.exp_lat == 1) check("ram_untouched", 32'(ena_cnt), 32'(ena_before));
  endtask

  initial begin
    int lat;
    vecs.push_back(mk(1, 8'd5,   32'hDEAD_BEEF, 4'hF, 32'h0,         0, 2));
    vecs.push_back(mk(0, 8'd5,   32'h0,         4'hF, 32'hDEAD_BEEF, 0, 3));
    vecs.push_back(mk(0, 8'd200, 32'h0,         4'hF, 32'hFFFF_FFFF, 1, 1));
    vecs.push_back(mk(1, 8'd203, 32'h0BAD_0BAD, 4'hF, 32'hFFFF_FFFF, 1, 1));
    vecs.push_back(mk(0, 8'd255, 32'h0,         4'hF, 32'hFFFF_FFFF, 1, 1));
    vecs.push_back(mk(1, 8'd0,   32'h1234_5678, 4'hF, 32'h0,         0, 2));
    vecs.push_back(mk(1, 8'd199, 32'hA5A5_5A5A, 4'hF, 32'h0,         0, 2));
    vecs.push_back(mk(0, 8'd199, 32'h0,         4'hF, 32'hA5A5_5A5A, 0, 3));
    vecs.push_back(mk(0, 8'd0,   32'h0,         4'hF, 32'h1234_5678, 0, 3));
    vecs.push_back(mk(1, 8'd7,   32'h1122_3344, 4'hF, 32'h0,         0, 2));
`ifdef RAM_ACC_BYTE_WE_EN
    vecs.push_back(mk(1, 8'd7,   32'hAABB_CCDD, 4'b0101, 32'h0,      0, 4));
    vecs.push_back(mk(0, 8'd7,   32'h0,         4'hF, 32'h11BB_33DD, 0, 3));
    vecs.push_back(mk(1, 8'd7,   32'h5555_5555, 4'h0, 32'h0,         0, 1));
    vecs.push_back(mk(0, 8'd7,   32'h0,         4'hF, 32'h11BB_33DD, 0, 3));
`else
    vecs.push_back(mk(1, 8'd7,   32'hAABB_CCDD, 4'b0101, 32'h0,      0, 2));
    vecs.push_back(mk(0, 8'd7,   32'h0,         4'hF, 32'hAABB_CCDD, 0, 3));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ram_ena", 32'(ram_ena), 32'd0);
    check("rst_ram_wea", 32'(ram_wea), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'd1);

    // Vector table
    foreach (vecs[i]) do_req(vecs[i], 1'b1);

    // Response backpressure for 10 cycles, then back-to-back accept
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", 32'(rsp_valid), 32'd0);
    do_req(mk(0, 8'd0, 32'h0, 4'hF, 32'h1234_5678, 0, 3), 1'b0);

    // Read timeout, then a normal load from IDLE
    suppress_rv = 1'b1;
    do_req(mk(0, 8'd5, 32'h0, 4'hF, 32'hFFFF_FFFF, 1, 2 + TIMEOUT), 1'b1);
    suppress_rv = 1'b0;
    do_req(mk(0, 8'd5, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 3), 1'b1);

    // Reset asserted while waiting for read data
    suppress_rv = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd199;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_issue_ena", 32'(ram_ena), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ram_ena", 32'(ram_ena), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    suppress_rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(mk(0, 8'd5, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 3), 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
